// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: count modes, count direction, channel slicing.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // LSB position of channel k in a packed per-channel vector of res-bit fields.
    function automatic int chan_lsb(input int k, input int res);
        return k * res;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up or up/down period counter, period boundary detection.
// Latency: boundary is combinational in the last cycle of a period; period_tick follows one clock later.
// Backpressure: none, free-running; mode/prescale are only taken at a period boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int nBitRes    = 12,
    parameter int PRESC_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [PRESC_BITS-1:0] prescale,
    output logic [nBitRes-1:0]    pwm_counter,
    output logic                  boundary,
    output logic                  period_tick
);

    localparam logic [nBitRes-1:0] MAX = '1;

    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PRESC_BITS-1:0] presc_act;
    logic                  mode_act;
    dir_t                  dir;

    logic                  adv;
    logic [nBitRes-1:0]    cnt_nxt;
    dir_t                  dir_nxt;

    // Next counter value and direction for the active mode, plus boundary detection.
    always_comb begin
        adv     = (presc_cnt == presc_act);
        cnt_nxt = pwm_counter;
        dir_nxt = dir;
        if (mode_act == MODE_EDGE) begin
            cnt_nxt = pwm_counter + 1'b1;
            dir_nxt = DIR_UP;
        end else begin
            if (dir == DIR_UP) begin
                cnt_nxt = pwm_counter + 1'b1;
            end else begin
                cnt_nxt = pwm_counter - 1'b1;
            end
            // Direction turns as the counter arrives at either end of its range.
            if (cnt_nxt == MAX) begin
                dir_nxt = DIR_DOWN;
            end else if (cnt_nxt == '0) begin
                dir_nxt = DIR_UP;
            end
        end
        boundary = adv && (cnt_nxt == '0);
    end

    // Prescaler, counter state and the per-period sampling of mode and prescale.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt   <= '0;
            presc_act   <= '0;
            mode_act    <= MODE_EDGE;
            dir         <= DIR_UP;
            pwm_counter <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            if (adv) begin
                presc_cnt   <= '0;
                pwm_counter <= cnt_nxt;
                dir         <= dir_nxt;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
            // A new period always starts counting up from zero, so a mode
            // switch taken here never inherits a stale direction.
            if (boundary) begin
                mode_act    <= mode;
                presc_act   <= prescale;
                pwm_counter <= '0;
                dir         <= DIR_UP;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one timebase, with double-buffered duty values loaded at period boundaries.
// Latency: pwmpin is registered, one clock behind pwm_counter; accepted duty goes live at the next boundary.
// Backpressure: duty_ready low while a vector is pending in the shadow buffer; a new one is taken only after the boundary load.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int nBitRes    = 12,
    parameter int PRESC_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH*nBitRes-1:0]   duty,
    input  logic                     duty_valid,
    output logic                     duty_ready,
    input  logic                     mode,
    input  logic [PRESC_BITS-1:0]    prescale,
    output logic                     period_tick,
    output logic [NCH-1:0]           pwmpin
);

    logic [nBitRes-1:0]     pwm_counter;
    logic                   boundary;

    logic [NCH*nBitRes-1:0] shadow;
    logic [NCH*nBitRes-1:0] active;
    logic                   pending;
    logic                   accept;
    logic [NCH-1:0]         pwm_nxt;

    pwm_timebase #(
        .nBitRes    (nBitRes),
        .PRESC_BITS (PRESC_BITS)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .prescale    (prescale),
        .pwm_counter (pwm_counter),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    assign duty_ready = !pending;
    assign accept     = duty_valid && duty_ready;

    // Shadow capture on handshake and whole-vector load into the active set at a boundary.
    // An accept coinciding with a boundary sees pending still low, so that
    // vector waits a full period rather than being loaded mid-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (accept) begin
                shadow  <= duty;
                pending <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign pwm_nxt[k] = (pwm_counter < active[chan_lsb(k, nBitRes) +: nBitRes]);
    end

    // Registered outputs keep the pins glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmpin <= '0;
        end else begin
            pwmpin <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues expected per-period pulse counts, a monitor checks each period.
// Latency: monitor windows are shifted one clock to absorb the registered output.
// Backpressure: exercises duty_ready held low while a vector is pending.
module tb_pwm_multi;

    localparam int NCH        = 2;
    localparam int NBITRES    = 4;
    localparam int PRESC_BITS = 10;

    logic                     clk;
    logic                     reset;
    logic [NCH*NBITRES-1:0]   duty;
    logic                     duty_valid;
    logic                     duty_ready;
    logic                     mode;
    logic [PRESC_BITS-1:0]    prescale;
    logic                     period_tick;
    logic [NCH-1:0]           pwmpin;

    typedef struct {
        int len;
        int h0;
        int h1;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pwm_multi #(
        .NCH        (NCH),
        .nBitRes    (NBITRES),
        .PRESC_BITS (PRESC_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .mode        (mode),
        .prescale    (prescale),
        .period_tick (period_tick),
        .pwmpin      (pwmpin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int len, input int h0, input int h1);
        exp_t e;
        e.len = len;
        e.h0  = h0;
        e.h1  = h1;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for a negedge where period_tick is high; n = negedges waited.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 200);
        if (!period_tick) check("tick_timeout", 0, 1);
    endtask

    // Monitor: a window covers the cycles after one tick up to and including the next tick.
    logic started   = 1'b0;
    logic prev_tick = 1'b0;
    int   win_len   = 0;
    int   win_h0    = 0;
    int   win_h1    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            started   = 1'b0;
            prev_tick = 1'b0;
            win_len   = 0;
            win_h0    = 0;
            win_h1    = 0;
        end else begin
            if (prev_tick) begin
                if (started) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_period", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("period_len", win_len, e.len);
                        check("ch0_high", win_h0, e.h0);
                        check("ch1_high", win_h1, e.h1);
                    end
                end
                started = 1'b1;
                win_len = 0;
                win_h0  = 0;
                win_h1  = 0;
            end
            win_len++;
            win_h0 += int'(pwmpin[0]);
            win_h1 += int'(pwmpin[1]);
            prev_tick = period_tick;
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        duty       = '0;
        duty_valid = 1'b0;
        mode       = 1'b0;
        prescale   = '0;

        // Reset state and idle edge-mode period.
        repeat (3) @(negedge clk);
        check("rst_pwmpin", int'(pwmpin), 0);
        check("rst_ready", int'(duty_ready), 1);
        check("rst_tick", int'(period_tick), 0);
        reset = 1'b0;
        wait_tick(n);
        check("first_tick_delay", n, 16);
        push(16, 0, 0);

        // Duty accepted mid-period goes live at the next boundary.
        wait_tick(n);
        push(16, 0, 0);
        repeat (5) @(negedge clk);
        check("ready_before_accept", int'(duty_ready), 1);
        duty       = 8'hF4;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("ready_after_accept", int'(duty_ready), 0);
        wait_tick(n);
        check("ready_after_load", int'(duty_ready), 1);
        push(16, 4, 15);

        // Switch to centre mode with ch0=5, ch1=MAX.
        wait_tick(n);
        push(16, 4, 15);
        repeat (3) @(negedge clk);
        mode       = 1'b1;
        duty       = 8'hF5;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        wait_tick(n);
        push(30, 9, 29);
        wait_tick(n);
        push(30, 9, 29);

        // Edge mode, prescale 3, ch0=8, ch1=0.
        repeat (3) @(negedge clk);
        mode       = 1'b0;
        prescale   = 10'd3;
        duty       = 8'h08;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        wait_tick(n);
        push(64, 32, 0);

        // Second vector held off while one is pending.
        prescale   = '0;
        duty       = 8'h32;
        duty_valid = 1'b1;
        check("ready_vec_a", int'(duty_ready), 1);
        @(negedge clk);
        duty = 8'h9A;
        check("ready_blocked", int'(duty_ready), 0);
        repeat (10) @(negedge clk);
        check("ready_still_blocked", int'(duty_ready), 0);
        wait_tick(n);
        check("ready_at_boundary", int'(duty_ready), 1);
        push(16, 2, 3);
        @(negedge clk);
        duty_valid = 1'b0;
        check("ready_vec_b_taken", int'(duty_ready), 0);
        wait_tick(n);
        check("ready_after_b_load", int'(duty_ready), 1);
        push(16, 10, 9);

        // Offer on the boundary cycle itself: live one full period later.
        repeat (15) @(negedge clk);
        check("pre_boundary_tick", int'(period_tick), 0);
        check("pre_boundary_ready", int'(duty_ready), 1);
        duty       = 8'h77;
        duty_valid = 1'b1;
        @(negedge clk);
        check("coincident_tick", int'(period_tick), 1);
        duty_valid = 1'b0;
        check("coincident_pending", int'(duty_ready), 0);
        push(16, 10, 9);
        wait_tick(n);
        check("ready_after_c_load", int'(duty_ready), 1);
        push(16, 7, 7);

        // Mid-period reset with active duty 7 and a pending vector.
        repeat (4) @(negedge clk);
        duty       = 8'h33;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("ready_d_pending", int'(duty_ready), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_pwmpin", int'(pwmpin), 0);
        check("rst2_ready", int'(duty_ready), 1);
        check("rst2_tick", int'(period_tick), 0);
        exp_q.delete();
        reset = 1'b0;
        wait_tick(n);
        check("rst2_first_tick_delay", n, 16);
        push(16, 0, 0);
        wait_tick(n);
        push(16, 0, 0);
        wait_tick(n);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
